// File: rtl/carfield_region_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------------+
// | carfield_region_responder: single-beat address-map responder with region decode and timeout.     |
// | Revision: 1.0                                                                                    |
// +--------------------------------------------------------------------------------------------------+
module carfield_region_responder #(
  parameter int unsigned                           NumRegions    = 4,
  parameter int unsigned                           AddrWidth     = 48,
  parameter int unsigned                           DataWidth     = 32,
  parameter logic [NumRegions-1:0]                 RegionEnable  = '1,
  parameter logic [NumRegions-1:0][AddrWidth-1:0]  RegionBase    = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0]  RegionSize    = '0,
  parameter int unsigned                           TimeoutCycles = 256,
  parameter logic [31:0]                           ErrData       = 32'hBADCAB1E
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [AddrWidth-1:0]             req_addr_i,
  input  logic                             req_write_i,
  input  logic [DataWidth-1:0]             req_wdata_i,
  input  logic [DataWidth/8-1:0]           req_wstrb_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DataWidth-1:0]             rsp_rdata_o,
  output logic                             rsp_error_o,
  output logic [NumRegions-1:0]            tgt_req_o,
  output logic [AddrWidth-1:0]             tgt_addr_o,
  output logic                             tgt_write_o,
  output logic [DataWidth-1:0]             tgt_wdata_o,
  output logic [DataWidth/8-1:0]           tgt_wstrb_o,
  input  logic [NumRegions-1:0]            tgt_ready_i,
  input  logic [NumRegions*DataWidth-1:0]  tgt_rdata_i,
  input  logic [NumRegions-1:0]            tgt_error_i,
  output logic                             timeout_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = (NumRegions > 1) ? $clog2(NumRegions) : 1;
  localparam int unsigned CntWidth  = $clog2(TimeoutCycles + 1);

  localparam logic [CntWidth-1:0]    CntLast     = CntWidth'(TimeoutCycles - 1);
  localparam logic [DataWidth+31:0]  ErrDataWide = {{DataWidth{1'b0}}, ErrData};
  localparam logic [DataWidth-1:0]   ErrDataW    = ErrDataWide[DataWidth-1:0];

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFwd  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  timeout_q, timeout_d;

  logic [NumRegions-1:0] w_hit;
  logic                  w_any_hit;
  logic [IdxWidth-1:0]   w_hit_idx;
  logic [DataWidth-1:0]  w_tgt_rdata [NumRegions];
  logic                  w_sel_ready;
  logic                  w_sel_error;
  logic [DataWidth-1:0]  w_sel_rdata;
  logic [NumRegions-1:0] w_tgt_req;

  // Region end is computed one bit wider so a region reaching the top of the map cannot wrap.
  for (genvar r = 0; r < NumRegions; r++) begin : g_region
    localparam logic [AddrWidth:0] RegionEnd = {1'b0, RegionBase[r]} + {1'b0, RegionSize[r]};
    assign w_hit[r]       = RegionEnable[r]
                            && (req_addr_i >= RegionBase[r])
                            && ({1'b0, req_addr_i} < RegionEnd);
    assign w_tgt_rdata[r] = tgt_rdata_i[r*DataWidth +: DataWidth];
  end

  // Scanning downwards lets the lowest matching index overwrite any higher one.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_idx = '0;
    for (int r = NumRegions - 1; r >= 0; r--) begin
      if (w_hit[r]) begin
        w_any_hit = 1'b1;
        w_hit_idx = IdxWidth'(r);
      end
    end
  end

  assign w_sel_ready = tgt_ready_i[idx_q];
  assign w_sel_error = tgt_error_i[idx_q];
  assign w_sel_rdata = w_tgt_rdata[idx_q];

  always_comb begin
    w_tgt_req = '0;
    if (state_q == StFwd) begin
      w_tgt_req[idx_q] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          if (w_any_hit) begin
            idx_d   = w_hit_idx;
            cnt_d   = '0;
            state_d = StFwd;
          end else begin
            rdata_d = ErrDataW;
            error_d = 1'b1;
            state_d = StResp;
          end
        end
      end
      StFwd: begin
        // A completion in the final allowed cycle takes priority over the timeout.
        if (w_sel_ready) begin
          rdata_d = write_q ? '0 : w_sel_rdata;
          error_d = w_sel_error;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d   = ErrDataW;
          error_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  assign req_ready_o = (state_q == StIdle) && !rst_i;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;
  assign tgt_req_o   = w_tgt_req;
  assign tgt_addr_o  = addr_q;
  assign tgt_write_o = write_q;
  assign tgt_wdata_o = wdata_q;
  assign tgt_wstrb_o = wstrb_q;
  assign timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_carfield_region_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------------+
// | tb_carfield_region_responder: directed vector bench for the region responder.                    |
// | Revision: 1.0                                                                                    |
// +--------------------------------------------------------------------------------------------------+
module tb_carfield_region_responder;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [47:0]  req_addr_i;
  logic         req_write_i;
  logic [31:0]  req_wdata_i;
  logic [3:0]   req_wstrb_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [31:0]  rsp_rdata_o;
  logic         rsp_error_o;
  logic [3:0]   tgt_req_o;
  logic [47:0]  tgt_addr_o;
  logic         tgt_write_o;
  logic [31:0]  tgt_wdata_o;
  logic [3:0]   tgt_wstrb_o;
  logic [3:0]   tgt_ready_i;
  logic [127:0] tgt_rdata_i;
  logic [3:0]   tgt_error_i;
  logic         timeout_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Region 0: 0x20001000+0x9000, region 1 disabled, region 2 and 3 overlap at 0x78000000.
  carfield_region_responder #(
    .NumRegions    (4),
    .AddrWidth     (48),
    .DataWidth     (32),
    .RegionEnable  (4'b1101),
    .RegionBase    ({48'h0000_7800_0000, 48'h0000_7000_0000, 48'h0000_4000_0000, 48'h0000_2000_1000}),
    .RegionSize    ({48'h0000_0000_1000, 48'h0000_1000_0000, 48'h0000_0010_0000, 48'h0000_0000_9000}),
    .TimeoutCycles (8),
    .ErrData       (32'hBADCAB1E)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .tgt_req_o   (tgt_req_o),
    .tgt_addr_o  (tgt_addr_o),
    .tgt_write_o (tgt_write_o),
    .tgt_wdata_o (tgt_wdata_o),
    .tgt_wstrb_o (tgt_wstrb_o),
    .tgt_ready_i (tgt_ready_i),
    .tgt_rdata_i (tgt_rdata_i),
    .tgt_error_i (tgt_error_i),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    logic [47:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          rdy_cyc;
    logic [3:0]  rdy_mask;
    logic [3:0]  err_mask;
    int          rsp_wait;
    logic [3:0]  exp_tgt;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rdy_cyc counts cycles after the accept edge; the target pulse is driven during that cycle.
  task automatic run_vec(input vec_t v);
    int         c;
    int         fwd;
    int         to_cnt;
    bit         done;
    logic [3:0] seen;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready_o), 64'(1));
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    req_write_i = v.wr;
    req_wdata_i = v.wdata;
    req_wstrb_i = v.wstrb;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    c = 1; fwd = 0; to_cnt = 0; done = 1'b0; seen = '0;
    while (!done && c <= 20) begin
      tgt_ready_i = '0;
      tgt_error_i = '0;
      if (tgt_req_o != 4'b0000) begin
        fwd++;
        seen |= tgt_req_o;
        if (fwd == 1) begin
          check("tgt_addr", 64'(tgt_addr_o), 64'(v.addr));
          check("tgt_write", 64'(tgt_write_o), 64'(v.wr));
          check("tgt_wdata", 64'(tgt_wdata_o), 64'(v.wdata));
          check("tgt_wstrb", 64'(tgt_wstrb_o), 64'(v.wstrb));
        end
      end
      if (timeout_o) to_cnt++;
      if (rsp_valid_o) begin
        check("rsp_latency", 64'(c), 64'(v.exp_lat));
        check("rsp_rdata", 64'(rsp_rdata_o), 64'(v.exp_rdata));
        check("rsp_error", 64'(rsp_error_o), 64'(v.exp_err));
        check("timeout_at_rsp", 64'(timeout_o), 64'(v.exp_to));
        for (int w = 0; w < v.rsp_wait; w++) begin
          @(negedge clk);
          if (timeout_o) to_cnt++;
          check("rsp_hold_valid", 64'(rsp_valid_o), 64'(1));
          check("rsp_hold_rdata", 64'(rsp_rdata_o), 64'(v.exp_rdata));
          check("rsp_hold_error", 64'(rsp_error_o), 64'(v.exp_err));
          check("req_ready_in_rsp", 64'(req_ready_o), 64'(0));
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid_o), 64'(0));
        check("req_ready_back", 64'(req_ready_o), 64'(1));
        done = 1'b1;
      end else begin
        if (c == v.rdy_cyc) begin
          tgt_ready_i = v.rdy_mask;
          tgt_error_i = v.err_mask;
        end
        @(negedge clk);
        c++;
      end
    end
    tgt_ready_i = '0;
    tgt_error_i = '0;
    if (!done) check("rsp_seen", 64'(0), 64'(1));
    check("fwd_cycles", 64'(fwd), 64'((v.exp_tgt != 4'b0000) ? v.exp_lat - 1 : 0));
    check("tgt_req_onehot", 64'(seen), 64'(v.exp_tgt));
    check("timeout_pulses", 64'(to_cnt), 64'(v.exp_to));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata_o), 64'(0));
    check({tag, "_rsp_error"}, 64'(rsp_error_o), 64'(0));
    check({tag, "_tgt_req"}, 64'(tgt_req_o), 64'(0));
    check({tag, "_tgt_addr"}, 64'(tgt_addr_o), 64'(0));
    check({tag, "_tgt_write"}, 64'(tgt_write_o), 64'(0));
    check({tag, "_tgt_wdata"}, 64'(tgt_wdata_o), 64'(0));
    check({tag, "_tgt_wstrb"}, 64'(tgt_wstrb_o), 64'(0));
    check({tag, "_timeout"}, 64'(timeout_o), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           addr            wr    wdata          wstrb rdy  rmask    emask    wait tgt      lat rdata          err   to
    vecs[0]  = '{48'h2000_4000, 1'b0, 32'h0,         4'hF, 1,   4'b0001, 4'b0000, 0,   4'b0001, 2,  32'h0000_1234, 1'b0, 1'b0};
    vecs[1]  = '{48'h3000_0000, 1'b0, 32'h0,         4'hF, 0,   4'b0000, 4'b0000, 2,   4'b0000, 1,  32'hBADC_AB1E, 1'b1, 1'b0};
    vecs[2]  = '{48'h4000_0010, 1'b1, 32'h0000_A5A5, 4'hF, 1,   4'b0010, 4'b0000, 0,   4'b0000, 1,  32'hBADC_AB1E, 1'b1, 1'b0};
    vecs[3]  = '{48'h2000_1000, 1'b0, 32'h0,         4'hF, 0,   4'b0000, 4'b0000, 1,   4'b0001, 9,  32'hBADC_AB1E, 1'b1, 1'b1};
    vecs[4]  = '{48'h2000_9FFC, 1'b0, 32'h0,         4'hF, 8,   4'b0001, 4'b0000, 0,   4'b0001, 9,  32'h0000_1234, 1'b0, 1'b0};
    vecs[5]  = '{48'h7800_0000, 1'b0, 32'h0,         4'hF, 1,   4'b0100, 4'b0100, 1,   4'b0100, 2,  32'h2222_0002, 1'b1, 1'b0};
    vecs[6]  = '{48'h7800_0800, 1'b1, 32'hDEAD_BEEF, 4'h3, 3,   4'b0100, 4'b0000, 0,   4'b0100, 4,  32'h0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{48'h2000_A000, 1'b0, 32'h0,         4'hF, 0,   4'b0000, 4'b0000, 0,   4'b0000, 1,  32'hBADC_AB1E, 1'b1, 1'b0};
    vecs[8]  = '{48'h2000_0FFF, 1'b0, 32'h0,         4'hF, 0,   4'b0000, 4'b0000, 0,   4'b0000, 1,  32'hBADC_AB1E, 1'b1, 1'b0};
    vecs[9]  = '{48'h2000_1000, 1'b0, 32'h0,         4'hF, 1,   4'b1110, 4'b1110, 0,   4'b0001, 9,  32'hBADC_AB1E, 1'b1, 1'b1};
    vecs[10] = '{48'h7FFF_FFFC, 1'b0, 32'h0,         4'hF, 2,   4'b0100, 4'b0000, 0,   4'b0100, 3,  32'h2222_0002, 1'b0, 1'b0};
    vecs[11] = '{48'h8000_0000, 1'b1, 32'h1111_2222, 4'hC, 0,   4'b0000, 4'b0000, 0,   4'b0000, 1,  32'hBADC_AB1E, 1'b1, 1'b0};
    vecs[12] = '{48'h2000_2000, 1'b1, 32'h5555_AAAA, 4'h1, 1,   4'b0001, 4'b0001, 0,   4'b0001, 2,  32'h0000_0000, 1'b1, 1'b0};

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    rsp_ready_i = 1'b0;
    tgt_ready_i = '0;
    tgt_error_i = '0;
    tgt_rdata_i = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_1234};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i]);
    end

    // Reset while a forwarded access is pending: no response may follow.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = 48'h2000_4000;
    req_write_i = 1'b1;
    req_wdata_i = 32'hCAFE_F00D;
    req_wstrb_i = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("midfwd_tgt_req", 64'(tgt_req_o), 64'(4'b0001));
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_fwd");
    rst_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rst_fwd_no_rsp", 64'({rsp_valid_o, timeout_o, tgt_req_o}), 64'(0));
    end

    // Reset while a response is being held.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = 48'h3000_0000;
    req_write_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("midrsp_valid", 64'(rsp_valid_o), 64'(1));
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_rsp");
    rst_i = 1'b0;

    run_vec(vecs[0]);
    run_vec(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
